// File: rtl/mux_4x1_5bit_pkg.sv
// Shared constants for the 4:1 mux: select codes and the default data width.
package mux_4x1_5bit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;
  localparam logic [1:0] SEL_IN3 = 2'b11;

endpackage

// File: rtl/mux_4x1_5bit_out_reg.sv
// Output register for the mux: holds the selected data and select code, and
// flags a change of the held data at the last edge.
module mux_out_reg
  import mux_4x1_5bit_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       sel_i,
  output logic [WIDTH-1:0] out_q_o,
  output logic [1:0]       sel_q_o,
  output logic             out_chg_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic [1:0]       sel_d, sel_q;
  logic             chg_d, chg_q;

  // Change is judged on data value only, so re-selecting equal data from a
  // different input does not raise the flag.
  always_comb begin
    data_d = d_i;
    sel_d  = sel_i;
    chg_d  = (d_i != data_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
      sel_q  <= SEL_IN0;
      chg_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      chg_q  <= chg_d;
    end
  end

  assign out_q_o   = data_q;
  assign sel_q_o   = sel_q;
  assign out_chg_o = chg_q;

endmodule

// File: rtl/mux_4x1_5bit.sv
// 4:1 data mux with a combinational output and parity, plus a registered
// copy of the output, select code and a one-cycle change flag.
module mux_4x1_5bit
  import mux_4x1_5bit_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q,
  output logic             out_chg,
  output logic             out_par
);

  // An unknown select must show up as X rather than silently picking in0.
  always_comb begin
    out = {WIDTH{1'bx}};
    case (sel)
      SEL_IN0: out = in0;
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_IN3: out = in3;
      default: out = {WIDTH{1'bx}};
    endcase
  end

  assign out_par = ^out;

  mux_out_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (out),
    .sel_i    (sel),
    .out_q_o  (out_q),
    .sel_q_o  (sel_q),
    .out_chg_o(out_chg)
  );

endmodule

// File: tb/tb_mux_4x1_5bit.sv
// Self-checking bench for mux_4x1_5bit: vector table, directed clocked
// sequences, then randomized traffic against a behavioural model.
module tb_mux_4x1_5bit;

  logic [4:0] din [4];
  logic [1:0] sel;
  logic       clk;
  logic       rst_n;
  logic [4:0] out, out_q;
  logic [1:0] sel_q;
  logic       out_chg, out_par;

  int n_vec  = 0;
  int n_fail = 0;

  mux_4x1_5bit dut (
    .in0    (din[0]),
    .in1    (din[1]),
    .in2    (din[2]),
    .in3    (din[3]),
    .sel    (sel),
    .out    (out),
    .clk    (clk),
    .rst_n  (rst_n),
    .out_q  (out_q),
    .sel_q  (sel_q),
    .out_chg(out_chg),
    .out_par(out_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] in0, in1, in2, in3;
    logic [1:0] sel;
    logic [4:0] exp_out;
    logic       exp_par;
  } vec_t;

  vec_t tbl [8];

  // reference model state
  logic [4:0] m_q;
  logic [1:0] m_sel;
  logic       m_chg;

  function automatic logic ref_par(input logic [4:0] v);
    return logic'($countones(v) % 2);
  endfunction

  initial begin
    tbl[0] = '{5'b00000, 5'b11001, 5'b11000, 5'b00111, 2'b00, 5'b00000, 1'b0};
    tbl[1] = '{5'b00000, 5'b11001, 5'b11000, 5'b00111, 2'b01, 5'b11001, 1'b1};
    tbl[2] = '{5'b00000, 5'b11001, 5'b11000, 5'b00111, 2'b10, 5'b11000, 1'b0};
    tbl[3] = '{5'b00000, 5'b11001, 5'b11000, 5'b00111, 2'b11, 5'b00111, 1'b1};
    tbl[4] = '{5'b00000, 5'b11001, 5'b00100, 5'b11011, 2'b11, 5'b11011, 1'b0};
    tbl[5] = '{5'b00000, 5'b11001, 5'b00100, 5'b11011, 2'b10, 5'b00100, 1'b1};
    tbl[6] = '{5'b11111, 5'b00001, 5'b10000, 5'b01110, 2'b01, 5'b00001, 1'b1};
    tbl[7] = '{5'b11111, 5'b00001, 5'b10000, 5'b01110, 2'b00, 5'b11111, 1'b1};

    rst_n = 1'b0;
    sel   = 2'b00;
    for (int k = 0; k < 4; k++) din[k] = 5'b0;
    #1;

    // Reset values without any clock edge yet
    chk("rst_out_q", out_q, 5'b0);
    chk("rst_sel_q", {3'b0, sel_q}, 5'b0);
    chk("rst_out_chg", {4'b0, out_chg}, 5'b0);

    // Combinational table, applied while held in reset (no clock dependence)
    for (int i = 0; i < 8; i++) begin
      din[0] = tbl[i].in0; din[1] = tbl[i].in1;
      din[2] = tbl[i].in2; din[3] = tbl[i].in3;
      sel    = tbl[i].sel;
      #1;
      chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_par", i), {4'b0, out_par}, {4'b0, tbl[i].exp_par});
      chk($sformatf("tbl%0d_out_q_in_rst", i), out_q, 5'b0);
      #19;
    end

    // Clocked run: release reset with sel=00, then step to 01
    @(negedge clk);
    din[0] = 5'b00000; din[1] = 5'b11001; din[2] = 5'b11000; din[3] = 5'b00111;
    sel = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_cap_out_q", out_q, 5'b00000);
    chk("first_cap_chg", {4'b0, out_chg}, 5'b0);
    @(negedge clk); sel = 2'b01;
    @(posedge clk); #1;
    chk("sel01_out_q", out_q, 5'b11001);
    chk("sel01_sel_q", {3'b0, sel_q}, 5'b00001);
    chk("sel01_chg", {4'b0, out_chg}, 5'b1);
    @(posedge clk); #1;
    chk("sel01_chg_drop", {4'b0, out_chg}, 5'b0);

    // Asynchronous reset between edges while holding 11000
    @(negedge clk); sel = 2'b10;
    @(posedge clk); #1;
    chk("pre_rst_out_q", out_q, 5'b11000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_q", out_q, 5'b00000);
    chk("async_rst_sel_q", {3'b0, sel_q}, 5'b0);
    chk("async_rst_chg", {4'b0, out_chg}, 5'b0);
    chk("async_rst_out", out, 5'b11000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_q", out_q, 5'b11000);
    chk("post_rst_chg_vs_resetval", {4'b0, out_chg}, 5'b1);

    // Equal data on two inputs: re-selection is not a change
    @(negedge clk);
    din[0] = 5'b10101; din[1] = 5'b10101; sel = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    chk("eq_settle_chg", {4'b0, out_chg}, 5'b0);
    @(negedge clk); sel = 2'b01;
    #1 chk("eq_out", out, 5'b10101);
    @(posedge clk); #1;
    chk("eq_out_q", out_q, 5'b10101);
    chk("eq_sel_q", {3'b0, sel_q}, 5'b00001);
    chk("eq_chg", {4'b0, out_chg}, 5'b0);

    // Non-selected input toggling
    @(negedge clk); sel = 2'b00;
    @(posedge clk); #1;
    @(negedge clk); din[3] = ~din[3];
    #1 chk("nonsel_out", out, 5'b10101);
    @(posedge clk); #1;
    chk("nonsel_out_q", out_q, 5'b10101);
    chk("nonsel_chg", {4'b0, out_chg}, 5'b0);

    // Randomized traffic against the model, starting from a fresh reset
    @(negedge clk); rst_n = 1'b0;
    m_q = 5'b0; m_sel = 2'b00; m_chg = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) din[k] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) din[$urandom_range(0, 3)] = din[sel];
      if ($urandom_range(0, 2) != 0) sel = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 19) != 0);
      #1;
      if (!rst_n) begin
        m_q = 5'b0; m_sel = 2'b00; m_chg = 1'b0;
      end
      chk("rnd_out", out, din[sel]);
      chk("rnd_par", {4'b0, out_par}, {4'b0, ref_par(din[sel])});
      chk("rnd_hold_out_q", out_q, m_q);
      @(posedge clk);
      if (rst_n) begin
        m_chg = (din[sel] != m_q);
        m_q   = din[sel];
        m_sel = sel;
      end
      #1;
      chk("rnd_out_q", out_q, m_q);
      chk("rnd_sel_q", {3'b0, sel_q}, {3'b0, m_sel});
      chk("rnd_chg", {4'b0, out_chg}, {4'b0, m_chg});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
